// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable data width, parity and stop bits.
// Characters leave on an AXI-Stream master port with {parity_err, frame_err} in tuser.
module uart_rx_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] M_axis_tdata,
    output logic [1:0]           M_axis_tuser,
    output logic                 M_axis_tvalid,
    input  logic                 M_axis_tready,
    output logic                 Overrun,
    output logic                 Rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF      = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_q;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_err;
    logic                 frame_err;

    // NOTE: the synchronizer flops are deliberately not reset, so rx_sync keeps
    // tracking the pin during Rst and a line held low through reset never looks like an edge.
    always_ff @(posedge Clk) begin
        rx_meta <= Rx;
        rx_sync <= rx_meta;
    end

    assign Rx_busy = (state != S_IDLE);

    always_ff @(posedge Clk) begin
        rx_q    <= rx_sync;
        Overrun <= 1'b0;
        if (M_axis_tvalid && M_axis_tready) begin
            M_axis_tvalid <= 1'b0;
        end
        if (state != S_IDLE) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end

        unique case (state)
            S_IDLE: begin
                cnt     <= '0;
                bit_cnt <= '0;
                if (!rx_sync && rx_q) begin
                    state      <= S_START;
                    parity_err <= 1'b0;
                    frame_err  <= 1'b0;
                end
            end
            S_START: begin
                if (cnt == HALF && rx_sync) begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end else if (cnt == LAST) begin
                    state <= S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == HALF) begin
                    shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
                end
                if (cnt == LAST) begin
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt <= '0;
                        state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (cnt == HALF) begin
                    parity_err <= ((^shreg) ^ rx_sync) != PAR_ODD;
                end
                if (cnt == LAST) begin
                    state <= S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == HALF) begin
                    frame_err <= frame_err | ~rx_sync;
                    // Commit at mid last-stop so the next start edge is caught without dead time.
                    if (bit_cnt == LAST_STOP) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        if (!M_axis_tvalid || M_axis_tready) begin
                            M_axis_tdata  <= shreg;
                            M_axis_tuser  <= {parity_err, frame_err | ~rx_sync};
                            M_axis_tvalid <= 1'b1;
                        end else begin
                            Overrun <= 1'b1;
                        end
                    end
                end
                if (cnt == LAST) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            default: state <= S_IDLE;
        endcase

        if (Rst) begin
            state         <= S_IDLE;
            rx_q          <= 1'b0;
            cnt           <= '0;
            bit_cnt       <= '0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            M_axis_tdata  <= '0;
            M_axis_tuser  <= '0;
            M_axis_tvalid <= 1'b0;
            Overrun       <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench: three receiver configurations driven with serial frames and
// compared against a frame-level scoreboard built from the line protocol.
module tb_uart_rx_cfg;
    localparam int NI = 3;
    localparam int CFG_D [NI] = '{8, 7, 9};
    localparam int CFG_C [NI] = '{16, 8, 4};
    localparam int CFG_P [NI] = '{0, 2, 1};
    localparam int CFG_S [NI] = '{1, 2, 1};

    typedef struct packed {
        int inst;
        int data;
        int user;
        int cyc;
    } item_t;

    logic Clk = 1'b0;
    logic Rst;
    logic rx     [NI];
    logic tready [NI];

    wire [8:0] tdata_w  [NI];
    wire [1:0] tuser_w  [NI];
    wire       tvalid_w [NI];
    wire       ovr_w    [NI];
    wire       busy_w   [NI];
    wire [7:0] td0;
    wire [6:0] td1;

    assign tdata_w[0] = {1'b0, td0};
    assign tdata_w[1] = {2'b00, td1};

    uart_rx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .Clk(Clk), .Rst(Rst), .Rx(rx[0]),
        .M_axis_tdata(td0), .M_axis_tuser(tuser_w[0]), .M_axis_tvalid(tvalid_w[0]),
        .M_axis_tready(tready[0]), .Overrun(ovr_w[0]), .Rx_busy(busy_w[0]));

    uart_rx_cfg #(.DATA_BITS(7), .CLKS_PER_BIT(8), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .Rx(rx[1]),
        .M_axis_tdata(td1), .M_axis_tuser(tuser_w[1]), .M_axis_tvalid(tvalid_w[1]),
        .M_axis_tready(tready[1]), .Overrun(ovr_w[1]), .Rx_busy(busy_w[1]));

    uart_rx_cfg #(.DATA_BITS(9), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .Clk(Clk), .Rst(Rst), .Rx(rx[2]),
        .M_axis_tdata(tdata_w[2]), .M_axis_tuser(tuser_w[2]), .M_axis_tvalid(tvalid_w[2]),
        .M_axis_tready(tready[2]), .Overrun(ovr_w[2]), .Rx_busy(busy_w[2]));

    always #5 Clk = ~Clk;

    int    cyc = 0;
    int    n_chk = 0;
    int    n_bad = 0;
    item_t obs_q [$];
    item_t exp_q [$];
    int    rd_ptr = 0;
    int    ex_ptr = 0;
    int    ovr_cnt  [NI] = '{0, 0, 0};
    int    ovr_cyc  [NI] = '{0, 0, 0};
    int    busy_cnt [NI] = '{0, 0, 0};

    always @(posedge Clk) cyc <= cyc + 1;

    // Observe transfers, overrun pulses and busy cycles away from the active edge.
    always @(negedge Clk) begin
        for (int i = 0; i < NI; i++) begin
            if (tvalid_w[i] && tready[i]) begin
                item_t it;
                it.inst = i;
                it.data = int'(tdata_w[i]);
                it.user = int'(tuser_w[i]);
                it.cyc  = cyc;
                obs_q.push_back(it);
            end
            if (ovr_w[i]) begin
                ovr_cnt[i] = ovr_cnt[i] + 1;
                ovr_cyc[i] = cyc;
            end
            if (busy_w[i]) busy_cnt[i] = busy_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    function automatic int frame_done_cyc(input int i, input int k);
        int c;
        c = CFG_C[i];
        return k + 4 + c * (CFG_D[i] + (CFG_P[i] != 0 ? 1 : 0) + CFG_S[i]) + c / 2 - 1;
    endfunction

    task automatic push_exp(input int i, input int data, input int user, input int when);
        item_t it;
        it.inst = i;
        it.data = data;
        it.user = user;
        it.cyc  = when;
        exp_q.push_back(it);
    endtask

    // Drive one frame LSB first; stop_low marks stop bits driven low.
    task automatic send_frame(input int i, input int data, input bit pflip, input int stop_low,
                              input int gap, input bit expect_it);
        int d, c, p, s, k, ones, pbit, mask, user;
        d    = CFG_D[i];
        c    = CFG_C[i];
        p    = CFG_P[i];
        s    = CFG_S[i];
        mask = (1 << d) - 1;
        k    = cyc;
        rx[i] = 1'b0;
        tick(c);
        for (int b = 0; b < d; b++) begin
            rx[i] = data[b];
            tick(c);
        end
        ones = $countones(data & mask);
        if (p != 0) begin
            pbit = (p == 2) ? (ones % 2) : (1 - ones % 2);
            if (pflip) pbit = 1 - pbit;
            rx[i] = pbit[0];
            tick(c);
        end
        for (int j = 0; j < s; j++) begin
            rx[i] = ((stop_low >> j) & 1) != 0 ? 1'b0 : 1'b1;
            tick(c);
        end
        rx[i] = 1'b1;
        user = ((pflip && p != 0) ? 2 : 0) + (((stop_low & ((1 << s) - 1)) != 0) ? 1 : 0);
        if (expect_it) push_exp(i, data & mask, user, frame_done_cyc(i, k));
        if (gap > 0) tick(gap);
    endtask

    task automatic drain(input string tag);
        item_t o, e;
        check($sformatf("%s_count", tag), obs_q.size() - rd_ptr, exp_q.size() - ex_ptr);
        while (rd_ptr < obs_q.size() && ex_ptr < exp_q.size()) begin
            o = obs_q[rd_ptr];
            e = exp_q[ex_ptr];
            check($sformatf("%s_inst", tag), o.inst, e.inst);
            check($sformatf("%s_tdata", tag), o.data, e.data);
            check($sformatf("%s_tuser", tag), o.user, e.user);
            if (e.cyc >= 0) check($sformatf("%s_cycle", tag), o.cyc, e.cyc);
            rd_ptr++;
            ex_ptr++;
        end
        rd_ptr = obs_q.size();
        ex_ptr = exp_q.size();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bc, k2, data, pflip, sl, gap;
        Rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            rx[i]     = 1'b1;
            tready[i] = 1'b1;
        end
        tick(5);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_tvalid%0d", i), int'(tvalid_w[i]), 0);
            check($sformatf("rst_tdata%0d", i), int'(tdata_w[i]), 0);
            check($sformatf("rst_tuser%0d", i), int'(tuser_w[i]), 0);
            check($sformatf("rst_overrun%0d", i), int'(ovr_w[i]), 0);
            check($sformatf("rst_busy%0d", i), int'(busy_w[i]), 0);
        end
        Rst = 1'b0;
        tick(3);

        // Default 8N1 character with exact latency.
        send_frame(0, 'hA5, 1'b0, 0, 4, 1'b1);
        drain("a5");

        // 7E2: good parity, then flipped parity.
        send_frame(1, 'h55, 1'b0, 0, 0, 1'b1);
        send_frame(1, 'h55, 1'b1, 0, 4, 1'b1);
        drain("parity");

        // Second stop bit low, then a break of three frame times.
        send_frame(1, 'h2B, 1'b0, 2, CFG_C[1], 1'b1);
        drain("stop2");
        k2 = cyc;
        rx[1] = 1'b0;
        push_exp(1, 0, 1, frame_done_cyc(1, k2));
        tick(3 * CFG_C[1] * 11);
        drain("break");
        rx[1] = 1'b1;
        tick(4 * CFG_C[1]);
        drain("break_idle");
        send_frame(1, 'h11, 1'b0, 0, 4, 1'b1);
        drain("break_recover");

        // Short glitch on the line is a false start.
        base = busy_cnt[0];
        rx[0] = 1'b0;
        tick(4);
        rx[0] = 1'b1;
        tick(40);
        bc = busy_cnt[0] - base;
        check("glitch_busy_window", int'(bc >= 1 && bc <= CFG_C[0] / 2), 1);
        drain("glitch");

        // Consumer stalled: second frame overruns, held word survives.
        tready[0] = 1'b0;
        base = ovr_cnt[0];
        send_frame(0, 'h12, 1'b0, 0, 0, 1'b0);
        k2 = cyc;
        send_frame(0, 'h34, 1'b0, 0, 4, 1'b0);
        check("ovr_pulses", ovr_cnt[0] - base, 1);
        check("ovr_cycle", ovr_cyc[0], frame_done_cyc(0, k2));
        check("ovr_tvalid", int'(tvalid_w[0]), 1);
        check("ovr_tdata", int'(tdata_w[0]), 'h12);
        drain("ovr_stalled");
        push_exp(0, 'h12, 0, -1);
        tready[0] = 1'b1;
        tick(2);
        check("ovr_tvalid_after", int'(tvalid_w[0]), 0);
        drain("ovr_accept");

        // Reset during data bit 4 of 0xFF while a word is held.
        tready[0] = 1'b0;
        send_frame(0, 'h77, 1'b0, 0, 4, 1'b0);
        rx[0] = 1'b0;
        tick(CFG_C[0]);
        rx[0] = 1'b1;
        tick(CFG_C[0] * 4 + CFG_C[0] / 2);
        check("pre_rst_busy", int'(busy_w[0]), 1);
        Rst = 1'b1;
        tick(1);
        Rst = 1'b0;
        check("mid_rst_tvalid", int'(tvalid_w[0]), 0);
        check("mid_rst_tdata", int'(tdata_w[0]), 0);
        check("mid_rst_tuser", int'(tuser_w[0]), 0);
        check("mid_rst_overrun", int'(ovr_w[0]), 0);
        check("mid_rst_busy", int'(busy_w[0]), 0);
        tready[0] = 1'b1;
        tick(CFG_C[0] * 6);
        send_frame(0, 'h3C, 1'b0, 0, 4, 1'b1);
        drain("after_rst");

        // Randomized frames per configuration.
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 8; n++) begin
                data  = int'($urandom);
                pflip = (CFG_P[i] != 0) ? int'($urandom_range(0, 1)) : 0;
                sl    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (1 << CFG_S[i]) - 1)) : 0;
                gap   = (sl != 0) ? CFG_C[i] : int'($urandom_range(0, 3));
                send_frame(i, data, pflip[0], sl, gap, 1'b1);
            end
            tick(4);
            drain($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
